imm_step_sequencer: RTL and testbench

Hardwired control-step sequencer for the Mini SRC datapath. It drives the fetch steps T0–T2 and the execute steps T3–T5 of immediate-format ALU instructions (addi, andi, ori), which are otherwise stepped by hand in benches. It waits on a memory-ready handshake during fetch and can run instructions back-to-back. It sits between the memory/IR and the datapath control inputs, and replaces the hand-written per-instruction state sequences.

---
 rtl/imm_step_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_imm_step_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_step_sequencer.sv
// imm_step_sequencer: control-step sequencer for Mini SRC immediate ALU ops.
// Runs fetch (T0-T2) and execute (T3-T5) for addi/andi/ori with a memory-ready wait.
// Ports:
//   clk, clr (sync active-low reset), run, mem_ready, ir_opcode
//   datapath control strobes, alu_instruction_bits
//   busy, done, illegal, instr_count
// Option: IMM_SEQ_INSTR_CNT_EN builds the saturating retired-instruction
// counter. Without it, instr_count is tied to 0.
module imm_step_sequencer #(
    parameter int          OP_W     = 5,
    parameter int          ALU_W    = 5,
    parameter logic [4:0]  OPC_ADDI = 5'b01100,
    parameter logic [4:0]  OPC_ANDI = 5'b01101,
    parameter logic [4:0]  OPC_ORI  = 5'b01110,
    parameter logic [4:0]  ALU_ADD  = 5'b00011,
    parameter logic [4:0]  ALU_AND  = 5'b00101,
    parameter logic [4:0]  ALU_OR   = 5'b00110,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic             mem_ready,
    input  logic [OP_W-1:0]  ir_opcode,
    output logic             pc_out,
    output logic             mar_in,
    output logic             inc_pc,
    output logic             z_in,
    output logic             zlow_out,
    output logic             pc_in,
    output logic             read,
    output logic             mdr_in,
    output logic             mdr_out,
    output logic             ir_in,
    output logic             grb,
    output logic             rout,
    output logic             y_in,
    output logic             c_out,
    output logic             gra,
    output logic             rin,
    output logic [ALU_W-1:0] alu_instruction_bits,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [OP_W-1:0] r_op;
    logic            r_illegal;
    logic            w_op_ok;

    assign w_op_ok = (ir_opcode == OP_W'(OPC_ADDI))
                  || (ir_opcode == OP_W'(OPC_ANDI))
                  || (ir_opcode == OP_W'(OPC_ORI));

    // State register
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Opcode is latched in T3 so later IR changes cannot alter the T4 ALU code.
    // The illegal flag is registered so it appears in the IDLE cycle after T3.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_op      <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= (r_state == S_T3) && !w_op_ok;
            if (r_state == S_T3) begin
                r_op <= ir_opcode;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = run ? S_T0 : S_IDLE;
            S_T0:    w_next = S_T1;
            S_T1:    w_next = mem_ready ? S_T2 : S_T1;
            S_T2:    w_next = S_T3;
            S_T3:    w_next = w_op_ok ? S_T4 : S_IDLE;
            S_T4:    w_next = S_T5;
            S_T5:    w_next = run ? S_T0 : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Moore output decode
    always_comb begin
        pc_out               = 1'b0;
        mar_in               = 1'b0;
        inc_pc               = 1'b0;
        z_in                 = 1'b0;
        zlow_out             = 1'b0;
        pc_in                = 1'b0;
        read                 = 1'b0;
        mdr_in               = 1'b0;
        mdr_out              = 1'b0;
        ir_in                = 1'b0;
        grb                  = 1'b0;
        rout                 = 1'b0;
        y_in                 = 1'b0;
        c_out                = 1'b0;
        gra                  = 1'b0;
        rin                  = 1'b0;
        alu_instruction_bits = '0;
        done                 = 1'b0;
        busy                 = (r_state != S_IDLE);
        case (r_state)
            S_T0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
                z_in   = 1'b1;
            end
            S_T1: begin
                zlow_out = 1'b1;
                pc_in    = 1'b1;
                read     = 1'b1;
                mdr_in   = 1'b1;
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            S_T3: begin
                grb  = 1'b1;
                rout = 1'b1;
                y_in = 1'b1;
            end
            S_T4: begin
                c_out = 1'b1;
                z_in  = 1'b1;
                if (r_op == OP_W'(OPC_ADDI)) begin
                    alu_instruction_bits = ALU_W'(ALU_ADD);
                end else if (r_op == OP_W'(OPC_ANDI)) begin
                    alu_instruction_bits = ALU_W'(ALU_AND);
                end else if (r_op == OP_W'(OPC_ORI)) begin
                    alu_instruction_bits = ALU_W'(ALU_OR);
                end
            end
            S_T5: begin
                zlow_out = 1'b1;
                gra      = 1'b1;
                rin      = 1'b1;
                done     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign illegal = r_illegal;

`ifdef IMM_SEQ_INSTR_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Saturating count of T5 cycles; only reset clears it.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_cnt <= '0;
        end else if ((r_state == S_T5) && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign instr_count = r_cnt;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_imm_step_sequencer.sv
// tb_imm_step_sequencer: directed checks for imm_step_sequencer.
// Two instances share stimulus: default CNT_W and CNT_W=2 (saturation).
module tb_imm_step_sequencer;

    logic       clk = 1'b0;
    logic       clr;
    logic       run;
    logic       mem_ready;
    logic [4:0] ir_opcode;

    logic [15:0] c1, c2;
    logic [4:0]  alu1, alu2;
    logic        busy1, busy2, done1, done2, ill1, ill2;
    logic [15:0] cnt1;
    logic [1:0]  cnt2;

    int n_asr  = 0;
    int n_fail = 0;

`ifdef IMM_SEQ_INSTR_CNT_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    localparam logic [15:0] C_ID = 16'h0000;
    localparam logic [15:0] C_T0 = 16'hF000;
    localparam logic [15:0] C_T1 = 16'h0F00;
    localparam logic [15:0] C_T2 = 16'h00C0;
    localparam logic [15:0] C_T3 = 16'h0038;
    localparam logic [15:0] C_T4 = 16'h1004;
    localparam logic [15:0] C_T5 = 16'h0803;

    always #5 clk = ~clk;

    imm_step_sequencer u_dut (
        .clk(clk), .clr(clr), .run(run), .mem_ready(mem_ready),
        .ir_opcode(ir_opcode),
        .pc_out(c1[15]), .mar_in(c1[14]), .inc_pc(c1[13]), .z_in(c1[12]),
        .zlow_out(c1[11]), .pc_in(c1[10]), .read(c1[9]), .mdr_in(c1[8]),
        .mdr_out(c1[7]), .ir_in(c1[6]), .grb(c1[5]), .rout(c1[4]),
        .y_in(c1[3]), .c_out(c1[2]), .gra(c1[1]), .rin(c1[0]),
        .alu_instruction_bits(alu1), .busy(busy1), .done(done1),
        .illegal(ill1), .instr_count(cnt1)
    );

    imm_step_sequencer #(.CNT_W(2)) u_dut2 (
        .clk(clk), .clr(clr), .run(run), .mem_ready(mem_ready),
        .ir_opcode(ir_opcode),
        .pc_out(c2[15]), .mar_in(c2[14]), .inc_pc(c2[13]), .z_in(c2[12]),
        .zlow_out(c2[11]), .pc_in(c2[10]), .read(c2[9]), .mdr_in(c2[8]),
        .mdr_out(c2[7]), .ir_in(c2[6]), .grb(c2[5]), .rout(c2[4]),
        .y_in(c2[3]), .c_out(c2[2]), .gra(c2[1]), .rin(c2[0]),
        .alu_instruction_bits(alu2), .busy(busy2), .done(done2),
        .illegal(ill2), .instr_count(cnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] ec,
                         input logic [4:0] ea, input logic eb,
                         input logic ed, input logic ei);
        logic [23:0] ev;
        ev = {ec, ea, eb, ed, ei};
        n_asr++;
        assert ({c1, alu1, busy1, done1, ill1} === ev) else begin
            n_fail++;
            $error("FAIL %s dut1 got %h expected %h", tag,
                   {c1, alu1, busy1, done1, ill1}, ev);
        end
        n_asr++;
        assert ({c2, alu2, busy2, done2, ill2} === ev) else begin
            n_fail++;
            $error("FAIL %s dut2 got %h expected %h", tag,
                   {c2, alu2, busy2, done2, ill2}, ev);
        end
    endtask

    // n is the number of instructions retired since the last reset.
    task automatic check_cnt(input string tag, input int n);
        logic [15:0] e1;
        logic [1:0]  e2;
        e1 = CE ? 16'(n) : 16'd0;
        e2 = CE ? ((n > 3) ? 2'd3 : 2'(n)) : 2'd0;
        n_asr++;
        assert (cnt1 === e1) else begin
            n_fail++;
            $error("FAIL %s cnt16 got %0d expected %0d", tag, cnt1, e1);
        end
        n_asr++;
        assert (cnt2 === e2) else begin
            n_fail++;
            $error("FAIL %s cnt2 got %0d expected %0d", tag, cnt2, e2);
        end
    endtask

    initial begin
        clr       = 1'b0;
        run       = 1'b0;
        mem_ready = 1'b0;
        ir_opcode = 5'b00000;
        step();
        step();
        check("reset", C_ID, 5'd0, 1'b0, 1'b0, 1'b0);
        check_cnt("reset_cnt", 0);
        clr = 1'b1;
        step();
        check("idle_norun", C_ID, 5'd0, 1'b0, 1'b0, 1'b0);

        // addi, zero wait; mem_ready high outside T1 is ignored
        run       = 1'b1;
        mem_ready = 1'b1;
        ir_opcode = 5'b01100;
        step();
        check("add_t0", C_T0, 5'd0, 1'b1, 1'b0, 1'b0);
        run = 1'b0;
        step();
        check("add_t1", C_T1, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        check("add_t2", C_T2, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        check("add_t3", C_T3, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        check("add_t4", C_T4, 5'b00011, 1'b1, 1'b0, 1'b0);
        step();
        check("add_t5", C_T5, 5'd0, 1'b1, 1'b1, 1'b0);
        step();
        check("add_idle", C_ID, 5'd0, 1'b0, 1'b0, 1'b0);
        check_cnt("add_cnt", 1);

        // addi with three wait cycles in T1
        run       = 1'b1;
        mem_ready = 1'b0;
        step();
        check("w_t0", C_T0, 5'd0, 1'b1, 1'b0, 1'b0);
        run = 1'b0;
        step();
        check("w_t1a", C_T1, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        check("w_t1b", C_T1, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        check("w_t1c", C_T1, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        check("w_t1d", C_T1, 5'd0, 1'b1, 1'b0, 1'b0);
        mem_ready = 1'b1;
        step();
        check("w_t2", C_T2, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        check("w_t3", C_T3, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        check("w_t4", C_T4, 5'b00011, 1'b1, 1'b0, 1'b0);
        step();
        check("w_t5", C_T5, 5'd0, 1'b1, 1'b1, 1'b0);
        step();
        check("w_idle", C_ID, 5'd0, 1'b0, 1'b0, 1'b0);
        check_cnt("w_cnt", 2);

        // unsupported opcode
        run       = 1'b1;
        ir_opcode = 5'b11111;
        step();
        check("il_t0", C_T0, 5'd0, 1'b1, 1'b0, 1'b0);
        run = 1'b0;
        step();
        check("il_t1", C_T1, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        check("il_t2", C_T2, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        check("il_t3", C_T3, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        check("il_pulse", C_ID, 5'd0, 1'b0, 1'b0, 1'b1);
        step();
        check("il_clear", C_ID, 5'd0, 1'b0, 1'b0, 1'b0);
        check_cnt("il_cnt", 2);

        // back-to-back ori then andi; opcode change in T4 must not matter
        run       = 1'b1;
        ir_opcode = 5'b01110;
        step();
        check("bb_t0a", C_T0, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        check("bb_t1a", C_T1, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        check("bb_t2a", C_T2, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        check("bb_t3a", C_T3, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        ir_opcode = 5'b01101;
        #1;
        check("bb_t4a_or", C_T4, 5'b00110, 1'b1, 1'b0, 1'b0);
        step();
        check("bb_t5a", C_T5, 5'd0, 1'b1, 1'b1, 1'b0);
        step();
        check("bb_t0b", C_T0, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        check("bb_t1b", C_T1, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        check("bb_t2b", C_T2, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        check("bb_t3b", C_T3, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        check("bb_t4b_and", C_T4, 5'b00101, 1'b1, 1'b0, 1'b0);
        run = 1'b0;
        step();
        check("bb_t5b", C_T5, 5'd0, 1'b1, 1'b1, 1'b0);
        step();
        check("bb_idle", C_ID, 5'd0, 1'b0, 1'b0, 1'b0);
        check_cnt("bb_cnt", 4);

        // reset during T4 aborts with no rin
        run       = 1'b1;
        ir_opcode = 5'b01100;
        step();
        run = 1'b0;
        step();
        step();
        step();
        step();
        check("rs_t4", C_T4, 5'b00011, 1'b1, 1'b0, 1'b0);
        clr = 1'b0;
        step();
        check("rs_abort", C_ID, 5'd0, 1'b0, 1'b0, 1'b0);
        check_cnt("rs_cnt", 0);
        clr = 1'b1;
        step();
        check("rs_after", C_ID, 5'd0, 1'b0, 1'b0, 1'b0);

        // five back-to-back addi: 16-bit count reaches 5, 2-bit saturates at 3
        run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("sat_t0", C_T0, 5'd0, 1'b1, 1'b0, 1'b0);
            step();
            step();
            step();
            step();
            if (i == 4) run = 1'b0;
            step();
            check("sat_t5", C_T5, 5'd0, 1'b1, 1'b1, 1'b0);
        end
        step();
        check("sat_idle", C_ID, 5'd0, 1'b0, 1'b0, 1'b0);
        check_cnt("sat_cnt", 5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asr, n_fail);
        $finish;
    end

endmodule
